seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter CHANNELS, default 4: number of input digits; range 2..8.
REQ-002 Parameter DATA_W, default 4: bits per digit; range 1..4; values are zero-extended to 4 bits before decoding.
REQ-003 Parameter PRESCALE, default 100000: clk cycles per scan step in auto mode; minimum 2.
REQ-004 Derived SEL_W = max(1, clog2(CHANNELS)).
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst, input, 1 bit: reset; asynchronous and active-high.
REQ-007 Port din, input, CHANNELS*DATA_W bits: channel k occupies din[k*DATA_W +: DATA_W].
REQ-008 Port mode, input, 1 bit: 0 = auto scan, 1 = manual select.
REQ-009 Port sel_in, input, SEL_W bits: channel index used in manual mode.
REQ-010 Port blank_mask, input, CHANNELS bits: bit k = 1 blanks channel k.
REQ-011 Port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-012 Port an, output, CHANNELS bits: active-low digit enables, one-cold or all ones, registered.
REQ-013 Port cur_sel, output, SEL_W bits: current channel index, registered.
REQ-014 Port step, output, 1 bit: one-cycle pulse when the prescaler reaches terminal count.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; step SHALL be 1 during the cycle in which the count equals PRESCALE-1.
REQ-016 In auto mode, on each cycle with step=1, cur_sel SHALL advance by 1 and wrap from CHANNELS-1 to 0.
REQ-017 In auto mode, cur_sel SHALL hold when step=0.
REQ-018 In manual mode, if sel_in < CHANNELS, cur_sel SHALL load sel_in on every clock.
REQ-019 In manual mode, if sel_in >= CHANNELS, cur_sel SHALL hold its value.
REQ-020 In manual mode, the prescaler SHALL be held at 0 and step SHALL be 0.
REQ-021 On a 1->0 transition of mode, scanning SHALL resume from the held cur_sel, and the first step SHALL occur PRESCALE cycles later.
REQ-022 seg and an SHALL be registered from the cur_sel value of the previous cycle: one cycle of latency after cur_sel.
REQ-023 seg SHALL be registered from the din and blank_mask values sampled on that same edge.
REQ-024 an SHALL drive the bit at index cur_sel low and all other bits high.
REQ-025 If blank_mask[cur_sel]=1, seg SHALL be 7'b1111111 and an SHALL be all ones.
REQ-026 The hex decode (active-low, {g..a}) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-027 Changes on din SHALL appear on seg on the next clock edge without waiting for step.

Reset
REQ-028 While rst=1, the following SHALL hold asynchronously:
- prescaler = 0, cur_sel = 0, step = 0
- seg = 7'b1111111, an = all ones
REQ-029 rst asserted mid-scan SHALL abort the scan immediately; after release, the first step SHALL occur at the PRESCALE-th rising edge.

Verification (CHANNELS=4, DATA_W=2, PRESCALE=4)
REQ-030 din={2'b11,2'b10,2'b01,2'b00}, mode=0, blank_mask=0, reset released -> step every 4 cycles; cur_sel 0,1,2,3,0; seg 1000000,1111001,0100100,0110000; an 1110,1101,1011,0111.
REQ-031 mode=1, sel_in=2 -> cur_sel=2 on the next edge; an=1011 and seg=0100100 one edge later; step stays 0.
REQ-032 Manual mode, cur_sel=2, then mode=0 -> cur_sel=3 exactly 4 cycles later.
REQ-033 blank_mask=4'b0010, auto mode -> when cur_sel=1, seg=1111111 and an=1111; other channels display normally.
REQ-034 rst pulsed while cur_sel=3 and prescaler=2 -> outputs reset immediately; after release, cur_sel=1 at the 4th edge.
REQ-035 Manual mode, din channel 0 changed 00->01 while cur_sel=0 -> seg goes 1000000->1111001 on the next edge.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: prescaled or manual channel selection,
// hex decode with per-channel blanking, registered segment/anode drive.
module seg_scan_mux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned PRESCALE = 100000,
    localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DATA_W-1:0]   din,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel_in,
    input  logic [CHANNELS-1:0]          blank_mask,
    output logic [6:0]                   seg,
    output logic [CHANNELS-1:0]          an,
    output logic [SEL_W-1:0]             cur_sel,
    output logic                         step
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0]    cnt;
    logic                term;
    logic                sel_valid;
    logic [DATA_W-1:0]   digit_c;
    logic [3:0]          nibble_c;
    logic                blank_c;
    logic [CHANNELS-1:0] an_c;
    logic [6:0]          seg_c;

    assign term      = (cnt == CNT_W'(PRESCALE - 1));
    assign step      = term & ~mode;
    assign sel_valid = ({1'b0, sel_in} < (SEL_W + 1)'(CHANNELS));

    // Prescaler: parked at zero in manual mode so auto scan restarts a full period later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (mode || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel <= '0;
        end else if (mode) begin
            if (sel_valid) begin
                cur_sel <= sel_in;
            end
        end else if (step) begin
            cur_sel <= (cur_sel == SEL_W'(CHANNELS - 1)) ? '0 : cur_sel + SEL_W'(1);
        end
    end

    // Channel mux and anode pattern for the current selection
    always_comb begin
        digit_c  = '0;
        blank_c  = 1'b0;
        an_c     = '1;
        nibble_c = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                digit_c  = din[k*DATA_W +: DATA_W];
                blank_c  = blank_mask[k];
                an_c[k]  = 1'b0;
            end
        end
        nibble_c[DATA_W-1:0] = digit_c;
    end

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seg_c = 7'b1111111;
        case (nibble_c)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
            default: seg_c = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '1;
            an  <= '1;
        end else begin
            seg <= blank_c ? 7'b1111111 : seg_c;
            an  <= blank_c ? '1 : an_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Table-driven bench for seg_scan_mux (4 channels, 2-bit digits, prescale 4)
// with a scoreboard queue and hand-written reset sequences.
module tb_seg_scan_mux;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DATA_W   = 2;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned NVEC     = 28;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       mode;
    logic [1:0] sel_in;
    logic [3:0] blank_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] cur_sel;
    logic       step;

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [1:0] sel_in;
        logic [3:0] blank;
        int         ncyc;
        logic [1:0] sel;
        logic [6:0] seg;
        logic [3:0] an;
        logic       step;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [6:0] seg;
        logic [3:0] an;
        logic       step;
    } exp_t;

    vec_t tbl[NVEC];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    seg_scan_mux #(
        .CHANNELS(CHANNELS),
        .DATA_W  (DATA_W),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .mode      (mode),
        .sel_in    (sel_in),
        .blank_mask(blank_mask),
        .seg       (seg),
        .an        (an),
        .cur_sel   (cur_sel),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] s, input logic [6:0] g, input logic [3:0] a, input logic st);
        exp_t e;
        e.sel = s; e.seg = g; e.an = a; e.step = st;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input int idx);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", idx, 8'd1, 8'd0);
        end else begin
            e = sbq.pop_front();
            chk("cur_sel", idx, 8'(cur_sel), 8'(e.sel));
            chk("seg",     idx, 8'(seg),     8'(e.seg));
            chk("an",      idx, 8'(an),      8'(e.an));
            chk("step",    idx, 8'(step),    8'(e.step));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // din E4 = {3,2,1,0}; seg codes: 0=40 1=79 2=24 3=30, blank=7F
        tbl[0]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 3, 2'd0, 7'h40, 4'hE, 1'b1};
        tbl[1]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 1, 2'd1, 7'h40, 4'hE, 1'b0};
        tbl[2]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 1, 2'd1, 7'h79, 4'hD, 1'b0};
        tbl[3]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 3, 2'd2, 7'h79, 4'hD, 1'b0};
        tbl[4]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 1, 2'd2, 7'h24, 4'hB, 1'b0};
        tbl[5]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 4, 2'd3, 7'h30, 4'h7, 1'b0};
        tbl[6]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 2, 2'd3, 7'h30, 4'h7, 1'b1};
        tbl[7]  = '{8'hE4, 1'b0, 2'd0, 4'h0, 2, 2'd0, 7'h40, 4'hE, 1'b0};
        tbl[8]  = '{8'hE4, 1'b1, 2'd2, 4'h0, 1, 2'd2, 7'h40, 4'hE, 1'b0};
        tbl[9]  = '{8'hE4, 1'b1, 2'd2, 4'h0, 1, 2'd2, 7'h24, 4'hB, 1'b0};
        tbl[10] = '{8'hE4, 1'b1, 2'd2, 4'h0, 5, 2'd2, 7'h24, 4'hB, 1'b0};
        tbl[11] = '{8'hE4, 1'b1, 2'd0, 4'h0, 1, 2'd0, 7'h24, 4'hB, 1'b0};
        tbl[12] = '{8'hE4, 1'b1, 2'd0, 4'h0, 1, 2'd0, 7'h40, 4'hE, 1'b0};
        tbl[13] = '{8'hE5, 1'b1, 2'd0, 4'h0, 1, 2'd0, 7'h79, 4'hE, 1'b0};
        tbl[14] = '{8'hE4, 1'b1, 2'd0, 4'h0, 1, 2'd0, 7'h40, 4'hE, 1'b0};
        tbl[15] = '{8'hE4, 1'b1, 2'd2, 4'h0, 2, 2'd2, 7'h24, 4'hB, 1'b0};
        tbl[16] = '{8'hE4, 1'b0, 2'd2, 4'h0, 3, 2'd2, 7'h24, 4'hB, 1'b1};
        tbl[17] = '{8'hE4, 1'b0, 2'd2, 4'h0, 1, 2'd3, 7'h24, 4'hB, 1'b0};
        tbl[18] = '{8'hE4, 1'b0, 2'd0, 4'h2, 1, 2'd3, 7'h30, 4'h7, 1'b0};
        tbl[19] = '{8'hE4, 1'b0, 2'd0, 4'h2, 3, 2'd0, 7'h30, 4'h7, 1'b0};
        tbl[20] = '{8'hE4, 1'b0, 2'd0, 4'h2, 1, 2'd0, 7'h40, 4'hE, 1'b0};
        tbl[21] = '{8'hE4, 1'b0, 2'd0, 4'h2, 3, 2'd1, 7'h40, 4'hE, 1'b0};
        tbl[22] = '{8'hE4, 1'b0, 2'd0, 4'h2, 1, 2'd1, 7'h7F, 4'hF, 1'b0};
        tbl[23] = '{8'hE4, 1'b0, 2'd0, 4'h2, 3, 2'd2, 7'h7F, 4'hF, 1'b0};
        tbl[24] = '{8'hE4, 1'b0, 2'd0, 4'h2, 1, 2'd2, 7'h24, 4'hB, 1'b0};
        tbl[25] = '{8'hF4, 1'b0, 2'd0, 4'h0, 1, 2'd2, 7'h30, 4'hB, 1'b0};
        tbl[26] = '{8'hE4, 1'b0, 2'd0, 4'h0, 1, 2'd2, 7'h24, 4'hB, 1'b1};
        tbl[27] = '{8'hE4, 1'b0, 2'd0, 4'h0, 3, 2'd3, 7'h30, 4'h7, 1'b0};

        rst        = 1'b1;
        din        = 8'hE4;
        mode       = 1'b0;
        sel_in     = 2'd0;
        blank_mask = 4'h0;

        // Held in reset across clock edges
        repeat (2) @(posedge clk);
        #1;
        push_exp(2'd0, 7'h7F, 4'hF, 1'b0);
        pop_cmp(-1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            din        = tbl[i].din;
            mode       = tbl[i].mode;
            sel_in     = tbl[i].sel_in;
            blank_mask = tbl[i].blank;
            push_exp(tbl[i].sel, tbl[i].seg, tbl[i].an, tbl[i].step);
            repeat (tbl[i].ncyc) @(posedge clk);
            #1;
            pop_cmp(i);
        end

        // Mid-scan asynchronous reset (cur_sel=3, prescaler=2), then restart timing
        #2;
        rst = 1'b1;
        #1;
        push_exp(2'd0, 7'h7F, 4'hF, 1'b0);
        pop_cmp(100);
        @(negedge clk);
        rst = 1'b0;
        push_exp(2'd0, 7'h40, 4'hE, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        pop_cmp(101);
        push_exp(2'd1, 7'h40, 4'hE, 1'b0);
        @(posedge clk);
        #1;
        pop_cmp(102);
        push_exp(2'd1, 7'h79, 4'hD, 1'b0);
        @(posedge clk);
        #1;
        pop_cmp(103);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
